// File: rtl/led_pulse_stretcher.sv
// Stretches one-cycle event strobes into visible LED blinks (ON period + OFF gap),
// queueing events that arrive mid-blink. Define LED_PULSE_OVF_EN to add the sticky ovf output.
module led_pulse_stretcher #(
  parameter int ON_TIME  = 10_000_000,
  parameter int OFF_TIME = 10_000_000,
  parameter int PEND_MAX = 15,
  parameter int PEND_W   = 4,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  input  logic              clear,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending
`ifdef LED_PULSE_OVF_EN
  ,
  output logic              ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    ON,
    GAP
  } state_t;

  localparam logic [CNT_W-1:0]  ON_LAST   = CNT_W'(ON_TIME - 1);
  localparam logic [CNT_W-1:0]  OFF_LAST  = CNT_W'(OFF_TIME - 1);
  localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(PEND_MAX);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic has_pend;
  logic start;
  logic enter_on;
  logic dec;
  logic direct;
  logic inc;

  // clear outranks queued events, so a flush during the last gap cycle lands in IDLE
  always_comb begin
    has_pend = (pending != '0);
    start    = !clear && (has_pend || pulse_in);
    enter_on = start && ((state == IDLE) || ((state == GAP) && (cnt == OFF_LAST)));
    dec      = enter_on && has_pend;
    direct   = enter_on && !has_pend;
    inc      = pulse_in && !clear && !direct;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      led_out <= 1'b0;
      busy    <= 1'b0;
      pending <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enter_on) begin
            state   <= ON;
            cnt     <= '0;
            led_out <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ON: begin
          if (cnt == ON_LAST) begin
            state   <= GAP;
            cnt     <= '0;
            led_out <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt == OFF_LAST) begin
            cnt <= '0;
            if (enter_on) begin
              state   <= ON;
              led_out <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          led_out <= 1'b0;
          busy    <= 1'b0;
        end
      endcase

      // an inc that meets a full queue with no matching dec is dropped
      if (clear) begin
        pending <= '0;
      end else if (inc && !dec && (pending != PEND_FULL)) begin
        pending <= pending + PEND_W'(1);
      end else if (dec && !inc) begin
        pending <= pending - PEND_W'(1);
      end
    end
  end

`ifdef LED_PULSE_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (inc && !dec && (pending == PEND_FULL)) begin
      ovf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Directed bench for led_pulse_stretcher with ON_TIME=4, OFF_TIME=3, PEND_MAX=3.
// Cycle c is the interval after clock edge c counted from the start of each scenario's reset.
module tb_led_pulse_stretcher;
  localparam int ON_TIME  = 4;
  localparam int OFF_TIME = 3;
  localparam int PEND_MAX = 3;
  localparam int PEND_W   = 4;
  localparam int CNT_W    = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pulse_in = 1'b0;
  logic              clear = 1'b0;
  logic              led_out;
  logic              busy;
  logic [PEND_W-1:0] pending;
`ifdef LED_PULSE_OVF_EN
  logic              ovf;
`endif

  int cyc = 0;
  int base = 0;
  int vectors = 0;
  int miscompares = 0;
  int starts[$];
  int pend_tab[$];

  led_pulse_stretcher #(
    .ON_TIME (ON_TIME),
    .OFF_TIME(OFF_TIME),
    .PEND_MAX(PEND_MAX),
    .PEND_W  (PEND_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pulse_in(pulse_in),
    .clear   (clear),
    .led_out (led_out),
    .busy    (busy),
`ifdef LED_PULSE_OVF_EN
    .ovf     (ovf),
`endif
    .pending (pending)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic gotoCycle(input int c);
    int guard = 0;
    while (((cyc - base) < c) && (guard < 1000)) begin
      @(posedge clk);
      #1;
      guard++;
    end
  endtask

  task automatic checkOutput(input string tag, input int c, input logic e_led, input logic e_busy,
                             input logic [PEND_W-1:0] e_pend, input logic e_ovf);
    vectors++;
    assert (led_out === e_led) else begin
      miscompares++;
      $error("[TB] FAIL %s cyc %0d led_out: got %b expected %b", tag, c, led_out, e_led);
    end
    vectors++;
    assert (busy === e_busy) else begin
      miscompares++;
      $error("[TB] FAIL %s cyc %0d busy: got %b expected %b", tag, c, busy, e_busy);
    end
    vectors++;
    assert (pending === e_pend) else begin
      miscompares++;
      $error("[TB] FAIL %s cyc %0d pending: got %0d expected %0d", tag, c, pending, e_pend);
    end
`ifdef LED_PULSE_OVF_EN
    vectors++;
    assert (ovf === e_ovf) else begin
      miscompares++;
      $error("[TB] FAIL %s cyc %0d ovf: got %b expected %b", tag, c, ovf, e_ovf);
    end
`else
    if (e_ovf) $display("[TB] note: %s expects an overflow that this build does not expose", tag);
`endif
  endtask

  task automatic doReset(input string tag);
    pulse_in = 1'b0;
    clear    = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    base = cyc;
    @(negedge clk);
    checkOutput({tag, "_reset"}, 0, 1'b0, 1'b0, '0, 1'b0);
    gotoCycle(2);
    rst = 1'b0;
  endtask

  // Drives pulse_in over [pf,pl] plus one extra cycle, clear on one cycle, and checks
  // every cycle from 10 to last against the hand-listed blink starts and pending table.
  task automatic applyStimulus(input string tag, input int pf, input int pl, input int pe,
                               input int clr, input int last, input int ovf_from);
    logic e_led, e_busy;
    for (int c = 10; c <= last; c++) begin
      gotoCycle(c);
      pulse_in = ((c >= pf) && (c <= pl)) || (c == pe);
      clear    = (c == clr);
      @(negedge clk);
      e_led  = 1'b0;
      e_busy = 1'b0;
      foreach (starts[i]) begin
        if ((c >= starts[i]) && (c < starts[i] + ON_TIME)) e_led = 1'b1;
        if ((c >= starts[i]) && (c < starts[i] + ON_TIME + OFF_TIME)) e_busy = 1'b1;
      end
      checkOutput(tag, c, e_led, e_busy, PEND_W'(pend_tab[c-10]),
                  (ovf_from >= 0) && (c >= ovf_from));
    end
    pulse_in = 1'b0;
    clear    = 1'b0;
  endtask

  initial begin
    doReset("single");
    starts   = '{11};
    pend_tab = '{0,0,0,0,0,0,0,0,0,0};
    applyStimulus("single", 10, 10, -1, -1, 19, -1);

    doReset("burst3");
    starts   = '{11, 18, 25};
    pend_tab = '{0,0,1,2,2,2,2,2, 1,1,1,1,1,1,1, 0,0,0,0,0,0,0,0,0};
    applyStimulus("burst3", 10, 12, -1, -1, 33, -1);

    doReset("sat");
    starts   = '{11, 18, 25, 32};
    pend_tab = '{0,0,1,2,3,3,3,3, 2,2,2,2,2,2,2, 1,1,1,1,1,1,1, 0,0,0,0,0,0,0,0,0};
    applyStimulus("sat", 10, 15, -1, -1, 40, 15);

    doReset("clear");
    starts   = '{11};
    pend_tab = '{0,0,1,2,0,0,0,0,0,0,0};
    applyStimulus("clear", 10, 12, -1, 13, 20, -1);

    doReset("chain");
    starts   = '{11, 18};
    pend_tab = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    applyStimulus("chain", 10, 10, 17, -1, 26, -1);

    // asynchronous reset in the middle of a blink
    doReset("rstmid");
    gotoCycle(10);
    pulse_in = 1'b1;
    gotoCycle(11);
    pulse_in = 1'b0;
    gotoCycle(12);
    @(negedge clk);
    checkOutput("rstmid_pre", 12, 1'b1, 1'b1, '0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rstmid_async", 12, 1'b0, 1'b0, '0, 1'b0);
    gotoCycle(13);
    rst = 1'b0;
    for (int c = 14; c <= 20; c++) begin
      gotoCycle(c);
      @(negedge clk);
      checkOutput("rstmid_after", c, 1'b0, 1'b0, '0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
